// File: rtl/lsuagu_pkg.sv
// Shared encodings and helpers for the split-capable load/store address-generation unit.
// Width helpers take XLEN so each module can derive its own bus geometry.
package lsuagu_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StCmd0 = 3'd1,
        StRsp0 = 3'd2,
        StCmd1 = 3'd3,
        StRsp1 = 3'd4,
        StWbck = 3'd5
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    function automatic int unsigned nb_of(input int unsigned xlen);
        return xlen / 8;
    endfunction

    function automatic int unsigned off_w_of(input int unsigned xlen);
        return $clog2(xlen / 8);
    endfunction

    // An access of 2**size bytes at byte offset off spills into the next bus word.
    function automatic logic is_split(input int unsigned off, input logic [1:0] size,
                                      input int unsigned nb);
        return (off + (32'd1 << size)) > nb;
    endfunction

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned NB       = nb_of(XLEN_DEF);
    localparam int unsigned OFF_W    = off_w_of(XLEN_DEF);

endpackage

// File: rtl/exu_lsuagu_lane.sv
// Byte-lane steering: spreads store data/mask across two bus beats and merges,
// aligns and extends the two load beats back into one register value.
module exu_lsuagu_lane
    import lsuagu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [off_w_of(XLEN)-1:0] off_i,
    input  logic [1:0]                size_i,
    input  logic                      usign_i,
    input  logic [XLEN-1:0]           rs2_i,
    input  logic [XLEN-1:0]           rdata0_i,
    input  logic [XLEN-1:0]           rdata1_i,
    output logic [2*XLEN-1:0]         wide_data_o,
    output logic [2*XLEN/8-1:0]       wide_mask_o,
    output logic [XLEN-1:0]           load_data_o
);

    localparam int unsigned NBL = nb_of(XLEN);
    localparam int unsigned OW  = off_w_of(XLEN);
    localparam int unsigned SW  = $clog2(2 * XLEN);

    logic [OW+2:0]      shamt;
    logic [2*XLEN-1:0]  merged;
    logic [2*NBL-1:0]   byte_mask;
    logic [SW-1:0]      sign_idx;
    logic               fill;
    int                 nbytes;

    assign shamt       = {off_i, 3'b000};
    assign wide_data_o = {{XLEN{1'b0}}, rs2_i} << shamt;
    assign merged      = {rdata1_i, rdata0_i} >> shamt;
    assign wide_mask_o = byte_mask << off_i;

    always_comb begin
        nbytes = int'(32'd1 << size_i);
        for (int i = 0; i < int'(2 * NBL); i++) begin
            byte_mask[i] = (i < nbytes);
        end
    end

    // Bits above the access width are filled from the access's top bit unless zero-extending.
    always_comb begin
        sign_idx = SW'(nbytes * 8 - 1);
        fill     = merged[sign_idx] & ~usign_i;
        for (int i = 0; i < int'(XLEN); i++) begin
            load_data_o[i] = (i < nbytes * 8) ? merged[i] : fill;
        end
    end

endmodule

// File: rtl/exu_lsuagu_split.sv
// Load/store AGU with one instruction in flight: computes rs1 + imm, issues one or two
// word-aligned bus beats, and writes back a single merged, extended result.
module exu_lsuagu_split
    import lsuagu_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned AW       = 16,
    parameter int unsigned ITAG_W   = 2,
    parameter bit          SPLIT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [XLEN-1:0]   i_rs1,
    input  logic [XLEN-1:0]   i_rs2,
    input  logic [XLEN-1:0]   i_imm,
    input  logic              i_load,
    input  logic              i_store,
    input  logic [1:0]        i_size,
    input  logic              i_usign,
    input  logic [ITAG_W-1:0] i_itag,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [AW-1:0]     cmd_addr,
    output logic              cmd_read,
    output logic [XLEN-1:0]   cmd_wdata,
    output logic [XLEN/8-1:0] cmd_wmask,
    output logic [ITAG_W-1:0] cmd_itag,
    input  logic              rsp_valid,
    output logic              rsp_ready,
    input  logic [XLEN-1:0]   rsp_rdata,
    input  logic              rsp_err,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [XLEN-1:0]   o_wdat,
    output logic [ITAG_W-1:0] o_itag,
    output logic              o_err,
    output logic              o_misalgn
);

    localparam int unsigned NBL = nb_of(XLEN);
    localparam int unsigned OW  = off_w_of(XLEN);

    lsu_state_e        state_q, state_d;
    logic [XLEN-1:0]   addr_q, rs2_q, rdata0_q, rdata1_q;
    logic [1:0]        size_q;
    logic              usign_q, load_q, split_q, err_q, misalgn_q;
    logic [ITAG_W-1:0] itag_q;

    logic [XLEN-1:0]   addr_sum;
    logic              split_in, accept, beat1;
    logic [AW-1:0]     beat0_addr, beat1_addr;
    logic [2*XLEN-1:0] wide_data;
    logic [2*NBL-1:0]  wide_mask;
    logic [XLEN-1:0]   load_data;

    assign addr_sum = i_rs1 + i_imm;
    assign split_in = is_split(32'(addr_sum[OW-1:0]), i_size, NBL);
    assign accept   = i_valid && (state_q == StIdle);

    assign beat0_addr = {addr_q[AW-1:OW], {OW{1'b0}}};
    assign beat1_addr = beat0_addr + AW'(NBL);

    exu_lsuagu_lane #(
        .XLEN(XLEN)
    ) u_lane (
        .off_i       (addr_q[OW-1:0]),
        .size_i      (size_q),
        .usign_i     (usign_q),
        .rs2_i       (rs2_q),
        .rdata0_i    (rdata0_q),
        .rdata1_i    (split_q ? rdata1_q : '0),
        .wide_data_o (wide_data),
        .wide_mask_o (wide_mask),
        .load_data_o (load_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (i_valid)   state_d = (split_in && !SPLIT_EN) ? StWbck : StCmd0;
            StCmd0: if (cmd_ready) state_d = StRsp0;
            StRsp0: if (rsp_valid) state_d = split_q ? StCmd1 : StWbck;
            StCmd1: if (cmd_ready) state_d = StRsp1;
            StRsp1: if (rsp_valid) state_d = StWbck;
            StWbck: if (o_ready)   state_d = StIdle;
            default:               state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            rs2_q     <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            size_q    <= SZ_B;
            usign_q   <= 1'b0;
            load_q    <= 1'b0;
            split_q   <= 1'b0;
            err_q     <= 1'b0;
            misalgn_q <= 1'b0;
            itag_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q    <= addr_sum;
                rs2_q     <= i_rs2;
                size_q    <= i_size;
                usign_q   <= i_usign;
                load_q    <= i_load && !i_store;
                itag_q    <= i_itag;
                split_q   <= split_in;
                misalgn_q <= split_in && !SPLIT_EN;
                err_q     <= 1'b0;
                rdata0_q  <= '0;
                rdata1_q  <= '0;
            end
            // Beat errors accumulate and only surface at write-back.
            if (state_q == StRsp0 && rsp_valid) begin
                rdata0_q <= rsp_rdata;
                err_q    <= err_q | rsp_err;
            end
            if (state_q == StRsp1 && rsp_valid) begin
                rdata1_q <= rsp_rdata;
                err_q    <= err_q | rsp_err;
            end
            if (state_q == StWbck && o_ready) begin
                err_q     <= 1'b0;
                misalgn_q <= 1'b0;
            end
        end
    end

    always_comb begin
        beat1     = (state_q == StCmd1);
        cmd_valid = (state_q == StCmd0) || beat1;
        cmd_addr  = beat1 ? beat1_addr : beat0_addr;
        cmd_read  = load_q;
        cmd_itag  = itag_q;
        cmd_wmask = beat1 ? wide_mask[2*NBL-1:NBL] : wide_mask[NBL-1:0];
        if (load_q) begin
            cmd_wdata = '0;
        end else begin
            cmd_wdata = beat1 ? wide_data[2*XLEN-1:XLEN] : wide_data[XLEN-1:0];
        end
    end

    assign i_ready   = (state_q == StIdle);
    assign rsp_ready = (state_q == StRsp0) || (state_q == StRsp1);
    assign o_valid   = (state_q == StWbck);
    assign o_itag    = itag_q;
    assign o_err     = o_valid && err_q;
    assign o_misalgn = o_valid && misalgn_q;

    always_comb begin
        o_wdat = '0;
        if (o_valid) begin
            if (misalgn_q)   o_wdat = addr_q;
            else if (load_q) o_wdat = load_data;
        end
    end

endmodule

// File: doc/exu_lsuagu_split.md
# exu_lsuagu_split

Parametrised load/store address-generation and access-sequencing unit, successor to the single-beat AGU in the EXU. It computes `rs1 + imm` with its own adder, issues one bus command for aligned accesses and two for accesses crossing an `XLEN/8`-byte word boundary, then merges, aligns and extends the load data. It writes back one result per instruction to the commit stage. It sits between EXU dispatch and the DTCM/LSU command/response channels, with one instruction in flight.

## Interface
Parameters:
- `XLEN`, 32: datapath width. Legal values are 32 and 64. `NB = XLEN/8` bytes per bus word.
- `AW`, 16: bus address width. `AW` ≤ `XLEN`.
- `ITAG_W`, 2: instruction tag width.
- `SPLIT_EN`, 1: when 1, misaligned accesses are split. When 0, they are rejected with `o_misalgn`.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset. Synchronous, active-high.
- `i_valid` / `i_ready`, in / out, 1: instruction handshake.
- `i_rs1`, `i_rs2`, `i_imm`, in, XLEN each: base address, store data, offset.
- `i_load`, `i_store`, in, 1 each: operation. Exactly one is set when `i_valid` is high.
- `i_size`, in, 2: access size. `00` = byte, `01` = half, `10` = word, `11` = double (legal only when XLEN=64).
- `i_usign`, in, 1: zero-extend the load result.
- `i_itag`, in, ITAG_W: instruction tag.
- `cmd_valid` / `cmd_ready`, out / in, 1: bus command handshake.
- `cmd_addr`, out, AW: word-aligned address. The low `log2(NB)` bits are always 0.
- `cmd_read`, out, 1: read command.
- `cmd_wdata`, out, XLEN: write data.
- `cmd_wmask`, out, NB: byte-enable mask.
- `cmd_itag`, out, ITAG_W: instruction tag.
- `rsp_valid` / `rsp_ready`, in / out, 1: bus response handshake.
- `rsp_rdata`, in, XLEN: read data.
- `rsp_err`, in, 1: response error.
- `o_valid` / `o_ready`, out / in, 1: write-back handshake.
- `o_wdat`, out, XLEN: write-back data.
- `o_itag`, out, ITAG_W: instruction tag.
- `o_err`, out, 1: bus error on any beat.
- `o_misalgn`, out, 1: misaligned access rejected.

## Operation
- States: `IDLE`, `CMD0`, `RSP0`, `CMD1`, `RSP1`, `WBCK`. The state register is one-hot or binary; encodings are defined in the package.
- Accept:
  - `i_ready = (state == IDLE)`.
  - On `i_valid & i_ready`, latch `addr = rs1 + imm` (mod 2^XLEN), `rs2`, `size`, `usign`, `load`, `itag`.
  - Compute `off = addr[log2(NB)-1:0]`, `bytes = 1 << size`, `split = (off + bytes > NB)`.
- Transitions out of `IDLE`:
  - If `split & !SPLIT_EN`: go to `WBCK` with `o_misalgn = 1` and `o_wdat = addr`. No command is issued.
  - Otherwise: go to `CMD0`.
- Lane vectors (2·NB bytes wide):
  - `wide_data = zext(rs2) << 8*off`.
  - `wide_mask = ((1 << bytes) - 1) << off`.
  - Beat 0 uses the low half; beat 1 uses the high half.
  - `cmd_wdata` is 0 for loads.
  - `cmd_wmask` carries the lane mask for loads as well as stores.
- `CMD0`: `cmd_valid = 1`, `cmd_addr = {addr[AW-1:log2 NB], 0}`. On `cmd_ready` go to `RSP0`.
- `RSP0`:
  - `rsp_ready = 1`.
  - On `rsp_valid`, capture `rsp_rdata` into the leftover register and OR `rsp_err` into the sticky error flag.
  - Go to `CMD1` if `split`, else `WBCK`.
- `CMD1`: `cmd_addr = beat-0 address + NB`, wrapping modulo 2^AW. On `cmd_ready` go to `RSP1`.
- `RSP1`: capture the second beat and OR its error into the sticky flag, then go to `WBCK`.
- Load merge:
  - `merged = {rdata1, leftover} >> 8*off`, where `rdata1 = 0` if not split.
  - Take the low `bytes` bytes, then sign- or zero-extend per `usign`.
- Store write-back: `o_wdat = 0`.
- `WBCK`: `o_valid = 1`. On `o_ready` go to `IDLE` and clear the error and misalign flags.
- Error handling: an erroring beat-0 response still proceeds to `CMD1`. The error is reported only at write-back.
- Reset:
  - The state goes to `IDLE` from any state.
  - Outputs at reset: `i_ready = 1`; `cmd_valid = rsp_ready = o_valid = 0`; `o_wdat = 0`; `o_err = o_misalgn = 0`.
  - A bus response still in flight at reset is not accepted (`rsp_ready = 0` in `IDLE`). The bus side must be reset together with this block.

## Timing
- All outputs are registered-state decodes. There is no combinational path from `i_*` to `cmd_*`.
- Minimum latency, aligned, no stalls: accept at T0, `cmd` handshake T1, `rsp` T2, `o_valid` T3. Throughput is one access per 4 cycles.
- Minimum latency, split: `o_valid` at T5.
- Minimum latency, rejected (`SPLIT_EN = 0`): `o_valid` at T1.
- While `cmd_valid` is high and `cmd_ready` is low, `cmd_addr`, `cmd_read`, `cmd_wdata`, `cmd_wmask` and `cmd_itag` hold stable.
- While `o_valid` is high and `o_ready` is low, `o_wdat`, `o_itag`, `o_err` and `o_misalgn` hold stable.
- `rsp_valid` is ignored outside `RSP0` and `RSP1`.

## Structure
- Package `lsuagu_pkg` holds:
  - the state encoding;
  - size codes `SZ_B`, `SZ_H`, `SZ_W`, `SZ_D`;
  - the `NB` and `OFF_W = log2(NB)` helper constants.
- Sub-module `exu_lsuagu_lane` is purely combinational and parametrised by `XLEN`. It computes:
  - from `off`, `size` and `rs2`: `wide_data` and `wide_mask`;
  - from `off`, `size`, `usign` and both beats: the merged, extended load result.
- The top level contains only the FSM, the adder, the operand/leftover registers and the handshakes.

## Test plan
- Aligned word load (XLEN=32), `rs1 = 0x100`, `imm = 4`:
  - one command: `addr 0x104`, `wmask 1111`, `read = 1`;
  - `rdata = 0xDEADBEEF` gives `o_wdat = 0xDEADBEEF` at T3.
- Byte loads at `0x103` with `rdata = 0x80000000`:
  - signed: `o_wdat = 0xFFFFFF80`;
  - unsigned: `o_wdat = 0x00000080`.
- Split word load at `0x102`:
  - `cmd0`: `addr 0x100`, `mask 1100`; `cmd1`: `addr 0x104`, `mask 0011`;
  - `rdata0 = 0xBBAA0000`, `rdata1 = 0x0000DDCC` gives `o_wdat = 0xDDCCBBAA`.
- Split word store at `0x103`, `rs2 = 0x11223344`:
  - `cmd0`: `mask 1000`, `wdata[31:24] = 0x44`;
  - `cmd1`: `mask 0111`, `wdata[23:0] = 0x112233`.
- Stalls and wrap:
  - `cmd_ready` held low for 3 cycles and `o_ready` low for 2: payload stays stable and `i_ready` stays 0;
  - `AW = 16`, half load at `0xFFFF`: `cmd1` address is `0x0000`;
  - `rst` asserted in `RSP1`: next cycle `i_ready = 1` with all valids 0.
- `SPLIT_EN = 0` and errors:
  - word load at `0x102`: no command is issued; `o_valid` at T1 with `o_misalgn = 1` and `o_wdat = 0x102`;
  - `SPLIT_EN = 1`, split load with `rsp_err` on beat 0: both beats are issued and the result has `o_err = 1`.
